// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4:1 round-robin mux arbiter: FSM encoding, source count,
// pointer reset value and the select-to-grant decoder.
package mux_arb_pkg;

   localparam int NSRC = 4;
   localparam logic [1:0] LP_RST = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic [NSRC-1:0] sel_to_gnt(input logic [1:0] s);
      sel_to_gnt = 4'b0001 << s;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way winner picker. Round-robin from (lp+1) by default; with
// MUX_ARB_FIXED_PRIO_EN defined, fixed priority (source 0 highest) and lp is ignored.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NSRC-1:0] req,
   input  logic [1:0]      lp,
   output logic            any,
   output logic [1:0]      win
);

   // Any-request flag.
   always_comb begin
      any = |req;
   end

`ifdef MUX_ARB_FIXED_PRIO_EN
   // Lowest set request bit wins.
   always_comb begin
      win = 2'd0;
      if (req[0]) begin
         win = 2'd0;
      end else if (req[1]) begin
         win = 2'd1;
      end else if (req[2]) begin
         win = 2'd2;
      end else if (req[3]) begin
         win = 2'd3;
      end else begin
         win = 2'd0;
      end
   end
`else
   // First set bit searching upward from lp+1; the last probe (k=NSRC) wraps back to lp.
   always_comb begin
      logic [1:0] idx;
      logic       found;
      win   = 2'd0;
      idx   = 2'd0;
      found = 1'b0;
      for (int k = 1; k <= NSRC; k++) begin
         idx = lp + 2'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
   end
`endif

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 4:1 mux feeding one valid/ready channel.
// Build option: MUX_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] req,
   input  logic [DW-1:0]   X0,
   input  logic [DW-1:0]   X1,
   input  logic [DW-1:0]   X2,
   input  logic [DW-1:0]   X3,
   input  logic            out_ready,
   output logic [DW-1:0]   out,
   output logic            out_valid,
   output logic [1:0]      sel,
   output logic [NSRC-1:0] gnt
);

   state_t          state_r, state_nxt_s;
   logic [DW-1:0]   out_r, out_nxt_s;
   logic            valid_r, valid_nxt_s;
   logic [1:0]      sel_r, sel_nxt_s;
   logic [NSRC-1:0] gnt_r, gnt_nxt_s;
   logic [1:0]      pick_lp_s;
   logic            any_s;
   logic [1:0]      win_s;
   logic [DW-1:0]   mux_s;

`ifdef MUX_ARB_FIXED_PRIO_EN
   // No last-served pointer in the fixed-priority build.
   always_comb begin
      pick_lp_s = 2'd0;
   end
`else
   logic [1:0] lp_r, lp_nxt_s;

   // A completed transfer makes the served source the new last-served pointer.
   always_comb begin
      if ((state_r == ST_HOLD) && out_ready) begin
         lp_nxt_s = sel_r;
      end else begin
         lp_nxt_s = lp_r;
      end
   end

   // Last-served pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lp_r <= LP_RST;
      end else begin
         lp_r <= lp_nxt_s;
      end
   end

   // In HOLD the re-arbitration starts after the word being accepted right now.
   always_comb begin
      if (state_r == ST_HOLD) begin
         pick_lp_s = sel_r;
      end else begin
         pick_lp_s = lp_r;
      end
   end
`endif

   rr_pick4 u_pick (
      .req (req),
      .lp  (pick_lp_s),
      .any (any_s),
      .win (win_s)
   );

   // Datapath mux driven by the candidate select code.
   always_comb begin
      case (win_s)
         2'd0:    mux_s = X0;
         2'd1:    mux_s = X1;
         2'd2:    mux_s = X2;
         2'd3:    mux_s = X3;
         default: mux_s = X0;
      endcase
   end

   // Next-state and output logic; a new word is loaded in IDLE or on an accepting HOLD cycle.
   always_comb begin
      state_nxt_s = state_r;
      out_nxt_s   = out_r;
      valid_nxt_s = valid_r;
      sel_nxt_s   = sel_r;
      gnt_nxt_s   = gnt_r;
      case (state_r)
         ST_IDLE: begin
            if (any_s) begin
               state_nxt_s = ST_HOLD;
               out_nxt_s   = mux_s;
               valid_nxt_s = 1'b1;
               sel_nxt_s   = win_s;
               gnt_nxt_s   = sel_to_gnt(win_s);
            end else begin
               valid_nxt_s = 1'b0;
               gnt_nxt_s   = 4'b0000;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               if (any_s) begin
                  state_nxt_s = ST_HOLD;
                  out_nxt_s   = mux_s;
                  valid_nxt_s = 1'b1;
                  sel_nxt_s   = win_s;
                  gnt_nxt_s   = sel_to_gnt(win_s);
               end else begin
                  state_nxt_s = ST_IDLE;
                  valid_nxt_s = 1'b0;
                  gnt_nxt_s   = 4'b0000;
               end
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
            gnt_nxt_s   = 4'b0000;
         end
      endcase
   end

   // State and output registers; reset discards any pending word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         out_r   <= '0;
         valid_r <= 1'b0;
         sel_r   <= 2'd0;
         gnt_r   <= 4'b0000;
      end else begin
         state_r <= state_nxt_s;
         out_r   <= out_nxt_s;
         valid_r <= valid_nxt_s;
         sel_r   <= sel_nxt_s;
         gnt_r   <= gnt_nxt_s;
      end
   end

   assign out       = out_r;
   assign out_valid = valid_r;
   assign sel       = sel_r;
   assign gnt       = gnt_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter; expected words are queued when driven
// and popped when the word appears on the output channel.
module tb_mux_rr_arbiter;

   typedef struct packed {
      logic [1:0] sel;
      logic [1:0] data;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [1:0] x0, x1, x2, x3;
   logic       out_ready;
   logic [1:0] out;
   logic       out_valid;
   logic [1:0] sel;
   logic [3:0] gnt;

   int   checks;
   int   failures;
   exp_t sb_q[$];
   exp_t cur;

   mux_rr_arbiter #(.DW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .X0        (x0),
      .X1        (x1),
      .X2        (x2),
      .X3        (x3),
      .out_ready (out_ready),
      .out       (out),
      .out_valid (out_valid),
      .sel       (sel),
      .gnt       (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_cur(input string tag);
      chk({tag, "_valid"}, 8'(out_valid), 8'd1);
      chk({tag, "_sel"},   8'(sel),       8'(cur.sel));
      chk({tag, "_gnt"},   8'(gnt),       8'(4'b0001 << cur.sel));
      chk({tag, "_out"},   8'(out),       8'(cur.data));
   endtask

   task automatic check_word(input string tag);
      chk({tag, "_avail"}, 8'(sb_q.size() > 0), 8'd1);
      if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         check_cur(tag);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, 8'(out_valid), 8'd0);
      chk({tag, "_gnt"},   8'(gnt),       8'd0);
   endtask

   function automatic logic [1:0] rr_exp(input int k);
`ifdef MUX_ARB_FIXED_PRIO_EN
      return 2'd0;
`else
      return 2'(k % 4);
`endif
   endfunction

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      req       = 4'($urandom_range(0, 15));
      x0        = 2'($urandom_range(0, 3));
      x1        = 2'($urandom_range(0, 3));
      x2        = 2'($urandom_range(0, 3));
      x3        = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));

      // Reset state, with and without clock edges
      #2;
      chk("rst_out", 8'(out), 8'd0);
      chk("rst_sel", 8'(sel), 8'd0);
      check_idle("rst");
      @(negedge clk);
      check_idle("rst_clk");
      rst_n     = 1'b1;
      req       = 4'b0000;
      out_ready = 1'b1;
      step();
      step();
      check_idle("post_rst");
      chk("post_rst_sel", 8'(sel), 8'd0);
      chk("post_rst_out", 8'(out), 8'd0);

      // Round-robin over all four sources, one word per cycle
      x0  = 2'd0;
      x1  = 2'd1;
      x2  = 2'd2;
      x3  = 2'd3;
      req = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         sb_q.push_back('{sel: rr_exp(k), data: rr_exp(k)});
      end
      for (int k = 0; k < 6; k++) begin
         step();
         check_word($sformatf("rr%0d", k));
      end
      req = 4'b0000;
      step();
      check_idle("rr_end");

      // Single request
      x2  = 2'b10;
      req = 4'b0100;
      sb_q.push_back('{sel: 2'd2, data: 2'b10});
      step();
      check_word("single");
      req = 4'b0000;
      step();
      check_idle("single_end");

      // Backpressure: word frozen while out_ready=0, X0 toggling
      x0        = 2'b01;
      x1        = 2'b11;
      req       = 4'b0011;
      out_ready = 1'b0;
      sb_q.push_back('{sel: 2'd0, data: 2'b01});
      step();
      check_word("bp_first");
      for (int k = 0; k < 5; k++) begin
         x0 = ~x0;
         step();
         check_cur($sformatf("bp_stall%0d", k));
      end
      out_ready = 1'b1;
      req       = 4'b0010;
      sb_q.push_back('{sel: 2'd1, data: 2'b11});
      step();
      check_word("bp_next");
      req = 4'b0000;
      step();
      check_idle("bp_end");

      // Fairness: source 0 served, then 0 and 3 compete
      x0  = 2'b10;
      x3  = 2'b01;
      req = 4'b0001;
      sb_q.push_back('{sel: 2'd0, data: 2'b10});
      step();
      check_word("fair_first");
      req = 4'b1001;
`ifdef MUX_ARB_FIXED_PRIO_EN
      sb_q.push_back('{sel: 2'd0, data: 2'b10});
`else
      sb_q.push_back('{sel: 2'd3, data: 2'b01});
`endif
      sb_q.push_back('{sel: 2'd0, data: 2'b10});
      step();
      check_word("fair_pick");
      step();
      check_word("fair_after");
      req = 4'b0000;
      step();
      check_idle("fair_end");

      // Mid-transfer reset discards the pending word
      x2        = 2'b11;
      req       = 4'b0100;
      out_ready = 1'b0;
      sb_q.push_back('{sel: 2'd2, data: 2'b11});
      step();
      check_word("mid_hold");
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("mid_rst");
      chk("mid_rst_sel", 8'(sel), 8'd0);
      chk("mid_rst_out", 8'(out), 8'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      x0        = 2'b01;
      x1        = 2'b10;
      x3        = 2'b10;
      req       = 4'b1111;
      out_ready = 1'b1;
      sb_q.push_back('{sel: 2'd0, data: 2'b01});
      step();
      check_word("mid_first");
      req = 4'b0000;
      step();
      check_idle("mid_end");
      chk("sb_empty", 8'(sb_q.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
